// File: rtl/ebus_arbiter_pkg.sv
// ebus_arbiter_pkg: shared EBUS op/state types and constant helpers for the diag-path arbiter.
package ebus_arbiter_pkg;
  typedef enum bit [1:0] {ebRead, ebWrite, ebDiag, ebIllegal} tEbusOp;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} tEbusArbState;
  function automatic int max3(int a, int b, int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/ebus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select of the first asserted req at or after ptr.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NREQ]) idx = PW'((int'(ptr) + i) % NREQ);
  end
endmodule

// File: rtl/ebus_arbiter.sv
// ebus_arbiter: round-robin owner of the EBUS diag path; sequences ds setup, diagStrobe, hold and ack.
module ebus_arbiter #(
  parameter int NREQ = 4,
  parameter int SETUP = 2,
  parameter int STROBE = 4,
  parameter int HOLD = 2
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0][1:0]  op,
  input  logic [NREQ-1:0][6:0]  ds,
  input  logic [NREQ-1:0][0:35] wdata,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic [0:35]           rdata,
  output logic                  busy,
  output logic [6:0]            EBUS_ds,
  output logic                  EBUS_diagStrobe,
  output logic                  EBUS_drive,
  output logic [0:35]           EBUS_dataOut,
  input  logic [0:35]           EBUS_dataIn
);
  import ebus_arbiter_pkg::*;
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(max3(SETUP, STROBE, HOLD)) + 1;
  tEbusArbState state_q, state_d;
  tEbusOp op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] g_q, g_d, ptr_q, ptr_d, idx;
  logic [6:0] ds_q, ds_d;
  logic [0:35] wd_q, wd_d, rdata_q, rdata_d;
  logic any, act, drv, cnt_z;
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (.req(req), .ptr(ptr_q), .any(any), .idx(idx));
  assign cnt_z = cnt_q == '0;
  // Phase states share names with the timing parameters, so they are scoped explicitly.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    g_d = g_q;
    op_d = op_q;
    ds_d = ds_q;
    wd_d = wd_q;
    ptr_d = ptr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (any) begin
        g_d = idx;
        op_d = tEbusOp'(op[idx]);
        ds_d = ds[idx];
        wd_d = wdata[idx];
        cnt_d = CW'(SETUP - 1);
        state_d = tEbusOp'(op[idx]) == ebIllegal ? DONE : ebus_arbiter_pkg::SETUP;
      end
      ebus_arbiter_pkg::SETUP: begin
        cnt_d = cnt_z ? CW'(STROBE - 1) : cnt_q - CW'(1);
        state_d = cnt_z ? ebus_arbiter_pkg::STROBE : state_q;
      end
      ebus_arbiter_pkg::STROBE: begin
        cnt_d = cnt_z ? CW'(HOLD - 1) : cnt_q - CW'(1);
        state_d = cnt_z ? ebus_arbiter_pkg::HOLD : state_q;
        rdata_d = (cnt_z && op_q == ebRead) ? EBUS_dataIn : rdata_q;
      end
      ebus_arbiter_pkg::HOLD: begin
        cnt_d = cnt_z ? cnt_q : cnt_q - CW'(1);
        state_d = cnt_z ? DONE : state_q;
      end
      DONE: begin
        ptr_d = (g_q == PW'(NREQ - 1)) ? '0 : g_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      g_q <= '0;
      op_q <= ebRead;
      ds_q <= '0;
      wd_q <= '0;
      ptr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      g_q <= g_d;
      op_q <= op_d;
      ds_q <= ds_d;
      wd_q <= wd_d;
      ptr_q <= ptr_d;
      rdata_q <= rdata_d;
    end
  end
  // Outputs decode only flopped state, so req never reaches the bus combinationally.
  assign act = state_q inside {ebus_arbiter_pkg::SETUP, ebus_arbiter_pkg::STROBE, ebus_arbiter_pkg::HOLD};
  assign drv = act && op_q == ebWrite;
  assign EBUS_ds = act ? ds_q : '0;
  assign EBUS_drive = drv;
  assign EBUS_dataOut = drv ? wd_q : '0;
  assign EBUS_diagStrobe = state_q == ebus_arbiter_pkg::STROBE;
  assign busy = state_q != IDLE;
  assign ack = state_q == DONE ? NREQ'(1) << g_q : '0;
  assign err = state_q == DONE && op_q == ebIllegal;
  assign rdata = rdata_q;
endmodule
